// File: rtl/sdf_pkg.sv
// -----------------------------------------------------------------------------
// sdf_pkg
// Shared definitions for the SDF NTT stage controllers:
//   state_t    - controller FSM encoding (2 bits)
//   clog2      - ceiling log2, used for counter widths
//   HALF_SPAN  - butterfly half-span D = N >> (STAGE+1)
//   STAGE_LAT  - input-to-output latency of one stage, D + 1 + DELAY_BTF
// -----------------------------------------------------------------------------
package sdf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int HALF_SPAN(input int logn, input int stage);
        return (1 << logn) >> (stage + 1);
    endfunction

    function automatic int STAGE_LAT(input int logn, input int stage, input int delay_btf);
        return HALF_SPAN(logn, stage) + 1 + delay_btf;
    endfunction

endpackage

// File: rtl/shiftreg.sv
// -----------------------------------------------------------------------------
// shiftreg
// Fixed-length delay line of DEPTH registers, WIDTH bits wide.
//   clk   in   clock
//   rst   in   asynchronous active-low reset, clears every stage
//   clr   in   synchronous clear of every stage (discards in-flight data)
//   din   in   WIDTH  data entering the line
//   dout  out  WIDTH  din delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module shiftreg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/sdf_btf_ctrl.sv
// -----------------------------------------------------------------------------
// sdf_btf_ctrl
// Stage controller for one single-path delay feedback NTT stage (CT butterfly).
// Counts the samples of one transform and drives the stage control signals.
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   start      in   request a transform (sampled only in IDLE)
//   intt       in   1 = inverse transform, latched on accepted start
//   in_valid   in   input sample present; must be contiguous for N cycles
//   busy       out  1 in every state except IDLE
//   fb_sel     out  1 = butterfly consumes, 0 = input written to the FIFO
//   tw_addr    out  LOGN  {intt, twiddle index}; MSB selects the ROM bank
//   out_sel    out  1 = output from butterfly out_a, 0 = from FIFO head
//   out_valid  out  stage output sample valid
//   done       out  one-cycle pulse after the last output sample
//   err        out  sticky: in_valid dropped mid-transform
// -----------------------------------------------------------------------------
module sdf_btf_ctrl
    import sdf_pkg::*;
#(
    parameter int LOGN      = 12,
    parameter int STAGE     = 0,
    parameter int DELAY_BTF = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            intt,
    input  logic            in_valid,
    output logic            busy,
    output logic            fb_sel,
    output logic [LOGN-1:0] tw_addr,
    output logic            out_sel,
    output logic            out_valid,
    output logic            done,
    output logic            err
);

    localparam int N      = 1 << LOGN;
    localparam int D      = HALF_SPAN(LOGN, STAGE);
    localparam int KW     = LOGN + 1;
    localparam int IW     = LOGN - 1;
    localparam int PH_BIT = LOGN - 1 - STAGE;
    localparam int DW     = clog2(DELAY_BTF + 1);

    localparam logic [KW-1:0] IDX_MASK    = KW'(D - 1);
    localparam logic [KW-1:0] K_D         = KW'(D);
    localparam logic [KW-1:0] K_LAST      = KW'(N - 1);
    localparam logic [KW-1:0] K_FLUSH_END = KW'(N + D - 1);
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DELAY_BTF);

    if (STAGE >= LOGN || STAGE < 0 || LOGN < 2 || DELAY_BTF < 1) begin : g_param_check
        $error("sdf_btf_ctrl: illegal parameters LOGN=%0d STAGE=%0d DELAY_BTF=%0d",
               LOGN, STAGE, DELAY_BTF);
    end

    state_t          state_reg;
    logic [KW-1:0]   k_reg;
    logic [DW-1:0]   drain_reg;
    logic            intt_reg;
    logic            valid_reg;
    logic [IW-1:0]   idx_shift;
    logic            abort;
    logic [1:0]      sr_out;

    // Twiddle index: position inside the half-span, scaled by the stage's
    // twiddle stride. idx < D so the shifted value never exceeds IW bits.
    assign idx_shift = IW'((k_reg & IDX_MASK) << STAGE);

    // A missing sample in RUN aborts the transform; the delayed control
    // pipeline is wiped so no partial transform is reported as valid.
    assign abort = (state_reg == ST_RUN) && !in_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            drain_reg <= '0;
            intt_reg  <= 1'b0;
            valid_reg <= 1'b0;
            busy      <= 1'b0;
            fb_sel    <= 1'b0;
            tw_addr   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done      <= 1'b0;
            fb_sel    <= 1'b0;
            valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        intt_reg  <= intt;
                        k_reg     <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        fb_sel    <= k_reg[PH_BIT];
                        tw_addr   <= {intt_reg, idx_shift};
                        // The first D samples only fill the delay line.
                        valid_reg <= (k_reg >= K_D);
                        k_reg     <= k_reg + 1'b1;
                        if (k_reg == K_LAST) begin
                            state_reg <= ST_FLUSH;
                        end
                    end else begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    // Phase 0 with zero input pushes the last D stored out_b
                    // values out of the delay line.
                    tw_addr   <= {intt_reg, idx_shift};
                    valid_reg <= 1'b1;
                    k_reg     <= k_reg + 1'b1;
                    if (k_reg == K_FLUSH_END) begin
                        drain_reg <= '0;
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_reg == DRAIN_LAST) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        drain_reg <= drain_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Both delayed controls travel through the butterfly latency together.
    shiftreg #(
        .WIDTH (2),
        .DEPTH (DELAY_BTF)
    ) u_btf_delay (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort),
        .din  ({fb_sel, valid_reg}),
        .dout (sr_out)
    );

    assign out_sel   = sr_out[1];
    assign out_valid = sr_out[0];

endmodule
